// File: rtl/booth_seq_mult.sv
// -----------------------------------------------------------------------------
// booth_seq_mult
//   Sequential radix-4 Booth multiplier core. It wraps an external Booth
//   encoder and computes a signed 32x32 -> 64 product in 16 steps.
//
//   The core latches the multiplicand and the multiplier. Each cycle it
//   presents one 3-bit multiplier window to the encoder. It then adds the
//   encoder's partial-product row into a 64-bit accumulator at weight 4^cnt.
//
// Ports
//   clk       in   1   rising-edge clock
//   rst       in   1   synchronous, active-high reset (has priority over start)
//   start     in   1   multiply request, sampled only while idle
//   a_in      in   32  signed multiplicand, latched on an accepted start
//   b_in      in   32  signed multiplier, latched on an accepted start
//   enc_a     out  32  latched multiplicand -> encoder A
//   enc_code  out  3   current Booth window -> encoder code
//   enc_pp    in   33  encoder partial product (combinational, same cycle)
//   enc_h     in   2   encoder negate flag (01 = add 1 at the row LSB)
//   enc_s     in   1   encoder inverted-sign flag
//   busy      out  1   high while a multiply is running or completing
//   done      out  1   one-cycle pulse; result is valid in this cycle
//   result    out  64  signed product, held until the next completion
//
// Configuration
//   BOOTH_EARLY_TERM_EN : when defined, the multiply ends early once every
//                         remaining window is 000/111 (zero rows). The product
//                         is unchanged; only the latency gets shorter.
// -----------------------------------------------------------------------------
module booth_seq_mult (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic [31:0] enc_a,
    output logic [2:0]  enc_code,
    input  logic [32:0] enc_pp,
    input  logic [1:0]  enc_h,
    input  logic        enc_s,
    output logic        busy,
    output logic        done,
    output logic [63:0] result
);

    localparam int STEPS = 16;
    localparam int ACC_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [32:0]        bsr;
    logic [3:0]         cnt;
    logic [ACC_W-1:0]   acc;

    logic [ACC_W-1:0]   row;
    logic [ACC_W-1:0]   row_shifted;
    logic [ACC_W-1:0]   acc_sum;
    logic [32:0]        bsr_shift;
    logic               last_step;

    // Datapath for one Booth step.
    // The sign-extended {~s, pp} plus h gives the true signed row value.
    // The accumulator is modulo 2^64. Wrap from the high rows cancels out
    // because the final product always fits in 64 bits.
    always_comb begin
        row         = {{(ACC_W-34){~enc_s}}, ~enc_s, enc_pp} + ACC_W'(enc_h);
        row_shifted = row << {cnt, 1'b0};
        acc_sum     = acc + row_shifted;
        bsr_shift   = {bsr[32], bsr[32], bsr[32:2]};
`ifdef BOOTH_EARLY_TERM_EN
        // Once the shifted register is all sign bits, every remaining window
        // is 000 or 111. Those windows all give zero rows.
        last_step   = (cnt == 4'(STEPS-1)) || (bsr_shift == '0) || (&bsr_shift);
`else
        last_step   = (cnt == 4'(STEPS-1));
`endif
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state and status outputs
    // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand, shift-register and accumulator datapath
    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            enc_a  <= '0;
            bsr    <= '0;
            cnt    <= '0;
            acc    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        enc_a <= a_in;
                        bsr   <= {b_in, 1'b0};
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    acc <= acc_sum;
                    bsr <= bsr_shift;
                    cnt <= cnt + 4'd1;
                    if (last_step) begin
                        result <= acc_sum;
                    end
                end
                DONE: begin
                    // Clear the window so the encoder sees code 000 while idle.
                    bsr <= '0;
                end
                default: begin
                    bsr <= '0;
                end
            endcase
        end
    end

    assign enc_code = bsr[2:0];

endmodule

// File: tb/tb_booth_seq_mult.sv
// -----------------------------------------------------------------------------
// tb_booth_seq_mult
//   Directed bench for booth_seq_mult. It contains a behavioural radix-4 Booth
//   encoder. The encoder maps each window to the (pp, s, h) triple the core
//   expects.
// -----------------------------------------------------------------------------
module tb_booth_seq_mult;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] enc_a;
    logic [2:0]  enc_code;
    logic [32:0] enc_pp;
    logic [1:0]  enc_h;
    logic        enc_s;
    logic        busy;
    logic        done;
    logic [63:0] result;

    int total_cnt;
    int pass_cnt;

    booth_seq_mult dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .enc_a    (enc_a),
        .enc_code (enc_code),
        .enc_pp   (enc_pp),
        .enc_h    (enc_h),
        .enc_s    (enc_s),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Booth encoder model.
    // The digit is d in {0, +-1, +-2}, and mag is |d|*A as a 34-bit signed value.
    // For a negative digit, the row is ~mag with h=1. The fields are
    // pp = x[32:0], s = ~x[33], where x is mag or ~mag.
    logic [33:0] mag;
    logic [33:0] xrow;
    logic        neg;
    always_comb begin
        mag  = '0;
        neg  = 1'b0;
        case (enc_code)
            3'b001, 3'b010: mag = {{2{enc_a[31]}}, enc_a};
            3'b011:         mag = {enc_a[31], enc_a, 1'b0};
            3'b100: begin
                mag = {enc_a[31], enc_a, 1'b0};
                neg = 1'b1;
            end
            3'b101, 3'b110: begin
                mag = {{2{enc_a[31]}}, enc_a};
                neg = 1'b1;
            end
            default: mag = '0;
        endcase
        xrow   = neg ? ~mag : mag;
        enc_pp = xrow[32:0];
        enc_s  = ~xrow[33];
        enc_h  = {1'b0, neg};
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Pulse start for one cycle with the given operands, then scramble the
    // operand inputs. Count the edges from the accept edge until done shows up.
    task automatic do_mult(input logic [31:0] a, input logic [31:0] b,
                           output logic [63:0] res, output int lat, output logic [31:0] ea);
        @(negedge clk);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        @(negedge clk);
        start = 1'b0;
        a_in  = $urandom;
        b_in  = $urandom;
        ea    = enc_a;
        lat   = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        res = result;
    endtask

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [63:0] res;
        logic [31:0] ea;
        int          lat;
        int          pulses;

        total_cnt = 0;
        pass_cnt  = 0;

        vecs[0] = '{"5x3",          32'd5,           32'd3,           64'h0000_0000_0000_000F};
        vecs[1] = '{"m1xm1",        32'hFFFF_FFFF,   32'hFFFF_FFFF,   64'h0000_0000_0000_0001};
        vecs[2] = '{"minxmin",      32'h8000_0000,   32'h8000_0000,   64'h4000_0000_0000_0000};
        vecs[3] = '{"maxxmin",      32'h7FFF_FFFF,   32'h8000_0000,   64'hC000_0000_8000_0000};
        vecs[4] = '{"maxxmax",      32'h7FFF_FFFF,   32'h7FFF_FFFF,   64'h3FFF_FFFF_0000_0001};
        vecs[5] = '{"m1x1",         32'hFFFF_FFFF,   32'd1,           64'hFFFF_FFFF_FFFF_FFFF};
        vecs[6] = '{"anyx0",        32'h1234_5678,   32'd0,           64'h0};
        vecs[7] = '{"m3xm7",        32'hFFFF_FFFD,   32'hFFFF_FFF9,   64'h0000_0000_0000_0015};
        vecs[8] = '{"2p16x2p16",    32'h0001_0000,   32'h0001_0000,   64'h0000_0001_0000_0000};

        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (2) @(negedge clk);

        check("reset_busy",   64'(busy),     64'd0);
        check("reset_done",   64'(done),     64'd0);
        check("reset_result", result,        64'd0);
        check("reset_enc_a",  64'(enc_a),    64'd0);
        check("reset_code",   64'(enc_code), 64'd0);
        rst = 1'b0;

        // Main table: product, fixed 16-edge latency, operand latch, one-cycle done
        for (int i = 0; i < 9; i++) begin
            do_mult(vecs[i].a, vecs[i].b, res, lat, ea);
            check({vecs[i].name, "_result"}, res, vecs[i].exp);
            check({vecs[i].name, "_latency"}, 64'(lat), 64'd16);
            check({vecs[i].name, "_enc_a"}, 64'(ea), 64'(vecs[i].a));
            @(negedge clk);
            check({vecs[i].name, "_done_width"}, 64'(done), 64'd0);
            check({vecs[i].name, "_idle_busy"}, 64'(busy), 64'd0);
            check({vecs[i].name, "_idle_code"}, 64'(enc_code), 64'd0);
        end

        // A start while busy is ignored: 7*9, with a 1*1 request at cycle 5
        @(negedge clk);
        start = 1'b1; a_in = 32'd7; b_in = 32'd9;
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        res    = '0;
        for (int c = 1; c <= 30; c++) begin
            if (c == 5) begin
                start = 1'b1; a_in = 32'd1; b_in = 32'd1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                pulses++;
                res = result;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("busy_start_result", res, 64'h3F);
        check("busy_start_pulses", 64'(pulses), 64'd1);
        check("busy_start_enc_a", 64'(enc_a), 64'd7);

        // Start held during the done cycle is ignored
        @(negedge clk);
        start = 1'b1; a_in = 32'd6; b_in = 32'd7;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("done_start_result", result, 64'd42);
        start = 1'b1; a_in = 32'd2; b_in = 32'd2;
        @(negedge clk);
        start = 1'b0;
        check("done_start_busy", 64'(busy), 64'd0);
        check("done_start_enc_a", 64'(enc_a), 64'd6);

        // Reset in the middle of a run
        @(negedge clk);
        start = 1'b1; a_in = 32'd7; b_in = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy",   64'(busy),     64'd0);
        check("rst_done",   64'(done),     64'd0);
        check("rst_result", result,        64'd0);
        check("rst_code",   64'(enc_code), 64'd0);
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        check("rst_no_done", 64'(pulses), 64'd0);

        do_mult(32'hFFFF_FFFE, 32'd3, res, lat, ea);
        check("post_rst_result", res, 64'hFFFF_FFFF_FFFF_FFFA);
        check("post_rst_latency", 64'(lat), 64'd16);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got no end, expected end");
        $fatal(1, "timeout");
    end

endmodule
